// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state type and memory-map constants for the data-memory responder
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  localparam logic [31:0] GPIO_ADDR  = 32'h0000_1000;
  localparam logic [31:0] CYCLE_ADDR = 32'h0000_1004;
endpackage

// File: rtl/dmem_if.sv
// dmem_if: memory-stage bus between the core (master) and the data-memory responder (slave)
interface dmem_if;
  logic        MemReqM;
  logic        MemWriteM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        MemStallM;
  logic        MisalignM;
  logic [31:0] GpioOut;
  modport master (
    output MemReqM, MemWriteM, ALUResultM, WriteDataM,
    input  ReadDataM, MemStallM, MisalignM, GpioOut
  );
  modport slave (
    input  MemReqM, MemWriteM, ALUResultM, WriteDataM,
    output ReadDataM, MemStallM, MisalignM, GpioOut
  );
endinterface

// File: rtl/dmem_ram.sv
// dmem_ram: single-port word RAM, synchronous write, asynchronous read, contents never reset
module dmem_ram #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH_WORDS];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: stalling data-memory responder with RAM, GPIO register and free-running cycle counter
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int READ_WAIT = 1
) (
  input logic clk,
  input logic reset,
  dmem_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  state_t state, state_n;
  logic [3:0] wcnt, wcnt_n;
  logic [31:0] cycle_cnt, gpio, rdata_ram, rd_mux;
  logic aligned, in_ram, load, store;
  assign aligned = bus.ALUResultM[1:0] == 2'b00;
  assign in_ram = bus.ALUResultM[31:AW+2] == '0;
  assign load = state == IDLE && bus.MemReqM && !bus.MemWriteM && aligned;
  assign store = reset && state == IDLE && bus.MemReqM && bus.MemWriteM && aligned;
  assign rd_mux = in_ram ? rdata_ram :
                  bus.ALUResultM == GPIO_ADDR ? gpio :
                  bus.ALUResultM == CYCLE_ADDR ? cycle_cnt : '0;
  assign bus.MemStallM = reset && (load || state == WAIT);
  assign bus.MisalignM = reset && state == IDLE && bus.MemReqM && !aligned;
  assign bus.GpioOut = gpio;
  dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk  (clk),
    .we   (store && in_ram),
    .addr (bus.ALUResultM[AW+1:2]),
    .wdata(bus.WriteDataM),
    .rdata(rdata_ram)
  );
  // DONE always falls back to IDLE so a still-asserted load is never reissued
  always_comb begin
    state_n = state;
    wcnt_n = wcnt;
    if (load) begin
      state_n = (READ_WAIT == 0) ? DONE : WAIT;
      wcnt_n = 4'(READ_WAIT);
    end else if (state == WAIT) begin
      wcnt_n = wcnt - 4'd1;
      state_n = (wcnt_n == 4'd0) ? DONE : WAIT;
    end else if (state == DONE) begin
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      wcnt <= '0;
      cycle_cnt <= '0;
      gpio <= '0;
      bus.ReadDataM <= '0;
    end else begin
      state <= state_n;
      wcnt <= wcnt_n;
      cycle_cnt <= cycle_cnt + 32'd1;
      if (store && bus.ALUResultM == GPIO_ADDR) gpio <= bus.WriteDataM;
      if (state_n == DONE) bus.ReadDataM <= rd_mux;
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table-driven cycle vectors plus directed corner sequences for dmem_responder
module tb_dmem_responder;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int errors = 0;
  int checks = 0;
  dmem_if b1();
  dmem_if b0();
  dmem_responder #(.DEPTH_WORDS(256), .READ_WAIT(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  dmem_responder #(.DEPTH_WORDS(256), .READ_WAIT(0)) dut0 (.clk(clk), .reset(reset), .bus(b0));
  always #5 clk = ~clk;
  typedef struct {
    logic req, we;
    logic [31:0] addr, wdata;
    logic stall, mis;
    logic [31:0] rd, gp;
  } vec_t;
  vec_t tv[$];
  function automatic vec_t mk(logic req, logic we, logic [31:0] addr, logic [31:0] wdata,
                              logic stall, logic mis, logic [31:0] rd, logic [31:0] gp);
    vec_t v;
    v.req = req; v.we = we; v.addr = addr; v.wdata = wdata;
    v.stall = stall; v.mis = mis; v.rd = rd; v.gp = gp;
    return v;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drv1(logic req, logic we, logic [31:0] addr, logic [31:0] wdata);
    b1.MemReqM = req; b1.MemWriteM = we; b1.ALUResultM = addr; b1.WriteDataM = wdata;
  endtask
  task automatic drv0(logic req, logic we, logic [31:0] addr, logic [31:0] wdata);
    b0.MemReqM = req; b0.MemWriteM = we; b0.ALUResultM = addr; b0.WriteDataM = wdata;
  endtask
  // Aligned load on dut1: two stall cycles, then DONE with the expected data
  task automatic do_load1(logic [31:0] addr, logic [31:0] exp, string name);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drv1(1'b1, 1'b0, addr, 32'h0);
      #1;
      chk({name, "_stall"}, 32'(b1.MemStallM), 32'(i < 2));
      if (i == 2) chk({name, "_rdata"}, b1.ReadDataM, exp);
    end
    @(negedge clk);
    drv1(1'b0, 1'b0, 32'h0, 32'h0);
  endtask
  initial begin
    drv1(1'b1, 1'b0, 32'h10, 32'h0);
    drv0(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    chk("rst_stall", 32'(b1.MemStallM), 32'd0);
    drv1(1'b1, 1'b0, 32'h12, 32'h0);
    #1;
    chk("rst_misalign", 32'(b1.MisalignM), 32'd0);
    @(negedge clk);
    #1;
    chk("rst_rdata", b1.ReadDataM, 32'h0);
    chk("rst_gpio", b1.GpioOut, 32'h0);
    drv1(1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    tv.push_back(mk(1, 1, 32'h10,   32'hDEADBEEF, 0, 0, 32'h0,        32'h0));
    tv.push_back(mk(1, 0, 32'h10,   32'h0,        1, 0, 32'h0,        32'h0));
    tv.push_back(mk(1, 0, 32'h10,   32'h0,        1, 0, 32'h0,        32'h0));
    tv.push_back(mk(1, 0, 32'h10,   32'h0,        0, 0, 32'hDEADBEEF, 32'h0));
    tv.push_back(mk(1, 1, 32'h12,   32'h11111111, 0, 1, 32'hDEADBEEF, 32'h0));
    tv.push_back(mk(1, 0, 32'h10,   32'h0,        1, 0, 32'hDEADBEEF, 32'h0));
    tv.push_back(mk(1, 0, 32'h10,   32'h0,        1, 0, 32'hDEADBEEF, 32'h0));
    tv.push_back(mk(1, 0, 32'h10,   32'h0,        0, 0, 32'hDEADBEEF, 32'h0));
    tv.push_back(mk(1, 1, 32'h1000, 32'h5A,       0, 0, 32'hDEADBEEF, 32'h0));
    tv.push_back(mk(1, 0, 32'h1000, 32'h0,        1, 0, 32'hDEADBEEF, 32'h5A));
    tv.push_back(mk(1, 0, 32'h1000, 32'h0,        1, 0, 32'hDEADBEEF, 32'h5A));
    tv.push_back(mk(1, 0, 32'h1000, 32'h0,        0, 0, 32'h5A,       32'h5A));
    tv.push_back(mk(1, 0, 32'h2000, 32'h0,        1, 0, 32'h5A,       32'h5A));
    tv.push_back(mk(1, 0, 32'h2000, 32'h0,        1, 0, 32'h5A,       32'h5A));
    tv.push_back(mk(1, 0, 32'h2000, 32'h0,        0, 0, 32'h0,        32'h5A));
    tv.push_back(mk(1, 1, 32'h1004, 32'h12345678, 0, 0, 32'h0,        32'h5A));
    tv.push_back(mk(1, 1, 32'h2000, 32'h99,       0, 0, 32'h0,        32'h5A));
    tv.push_back(mk(0, 0, 32'h10,   32'h0,        0, 0, 32'h0,        32'h5A));
    tv.push_back(mk(1, 0, 32'h13,   32'h0,        0, 1, 32'h0,        32'h5A));
    tv.push_back(mk(1, 1, 32'h1001, 32'hFF,       0, 1, 32'h0,        32'h5A));
    tv.push_back(mk(0, 1, 32'h1000, 32'h77,       0, 0, 32'h0,        32'h5A));
    tv.push_back(mk(1, 1, 32'h20,   32'hCAFEF00D, 0, 0, 32'h0,        32'h5A));
    tv.push_back(mk(1, 0, 32'h20,   32'h0,        1, 0, 32'h0,        32'h5A));
    tv.push_back(mk(1, 0, 32'h20,   32'h0,        1, 0, 32'h0,        32'h5A));
    tv.push_back(mk(1, 0, 32'h20,   32'h0,        0, 0, 32'hCAFEF00D, 32'h5A));
    tv.push_back(mk(1, 1, 32'h3FC,  32'hA5A5A5A5, 0, 0, 32'hCAFEF00D, 32'h5A));
    tv.push_back(mk(1, 0, 32'h400,  32'h0,        1, 0, 32'hCAFEF00D, 32'h5A));
    tv.push_back(mk(1, 0, 32'h400,  32'h0,        1, 0, 32'hCAFEF00D, 32'h5A));
    tv.push_back(mk(1, 0, 32'h400,  32'h0,        0, 0, 32'h0,        32'h5A));
    tv.push_back(mk(1, 0, 32'h3FC,  32'h0,        1, 0, 32'h0,        32'h5A));
    tv.push_back(mk(1, 0, 32'h3FC,  32'h0,        1, 0, 32'h0,        32'h5A));
    tv.push_back(mk(1, 0, 32'h3FC,  32'h0,        0, 0, 32'hA5A5A5A5, 32'h5A));
    tv.push_back(mk(0, 0, 32'h0,    32'h0,        0, 0, 32'hA5A5A5A5, 32'h5A));
    foreach (tv[i]) begin
      @(negedge clk);
      drv1(tv[i].req, tv[i].we, tv[i].addr, tv[i].wdata);
      #1;
      chk($sformatf("v%0d_stall", i), 32'(b1.MemStallM), 32'(tv[i].stall));
      chk($sformatf("v%0d_misalign", i), 32'(b1.MisalignM), 32'(tv[i].mis));
      chk($sformatf("v%0d_rdata", i), b1.ReadDataM, tv[i].rd);
      chk($sformatf("v%0d_gpio", i), b1.GpioOut, tv[i].gp);
    end
    // counter wrap: FFFF_FFFE -> FFFF_FFFF (idle) -> 0 on the edge entering DONE
    @(negedge clk);
    force dut1.cycle_cnt = 32'hFFFF_FFFE;
    #1;
    release dut1.cycle_cnt;
    do_load1(32'h1004, 32'h0, "cnt_wrap");
    do_load1(32'h3FC, 32'hA5A5A5A5, "pre_rst");
    drv1(1'b1, 1'b0, 32'h3FC, 32'h0);
    #1;
    chk("wait_rst_stall_before", 32'(b1.MemStallM), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("wait_rst_stall_forced", 32'(b1.MemStallM), 32'd0);
    chk("wait_rst_misalign", 32'(b1.MisalignM), 32'd0);
    @(negedge clk);
    #1;
    chk("wait_rst_stall", 32'(b1.MemStallM), 32'd0);
    chk("wait_rst_rdata", b1.ReadDataM, 32'h0);
    chk("wait_rst_gpio", b1.GpioOut, 32'h0);
    drv1(1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    do_load1(32'h3FC, 32'hA5A5A5A5, "post_rst");
    @(negedge clk);
    drv0(1'b1, 1'b1, 32'h0, 32'h11111111);
    #1;
    chk("rw0_st0_stall", 32'(b0.MemStallM), 32'd0);
    @(negedge clk);
    drv0(1'b1, 1'b1, 32'h4, 32'h22222222);
    #1;
    chk("rw0_st4_stall", 32'(b0.MemStallM), 32'd0);
    @(negedge clk);
    drv0(1'b1, 1'b0, 32'h0, 32'h0);
    #1;
    chk("rw0_ld0_stall", 32'(b0.MemStallM), 32'd1);
    @(negedge clk);
    #1;
    chk("rw0_ld0_done_stall", 32'(b0.MemStallM), 32'd0);
    chk("rw0_ld0_rdata", b0.ReadDataM, 32'h11111111);
    @(negedge clk);
    drv0(1'b1, 1'b0, 32'h4, 32'h0);
    #1;
    chk("rw0_ld4_stall", 32'(b0.MemStallM), 32'd1);
    chk("rw0_ld4_hold", b0.ReadDataM, 32'h11111111);
    @(negedge clk);
    #1;
    chk("rw0_ld4_done_stall", 32'(b0.MemStallM), 32'd0);
    chk("rw0_ld4_rdata", b0.ReadDataM, 32'h22222222);
    @(negedge clk);
    drv0(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("rw0_idle_stall", 32'(b0.MemStallM), 32'd0);
    @(negedge clk);
    #1;
    chk("rw0_idle_rdata", b0.ReadDataM, 32'h22222222);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit RAM words (power of two).
REQ-002 Parameter READ_WAIT, default 1, extra wait cycles per read (0..15).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  reset is synchronous and active-low: state initialised on a rising clk edge while reset=0.
REQ-005 MemReqM  in  1  memory-stage request valid (load or store).
REQ-006 MemWriteM  in  1  1=store, 0=load; qualified by MemReqM.
REQ-007 ALUResultM  in  32  byte address of the access.
REQ-008 WriteDataM  in  32  store data.
REQ-009 ReadDataM  out  32  load data, registered.
REQ-010 MemStallM  out  1  holds the pipeline; the core keeps all M-stage inputs stable while high.
REQ-011 MisalignM  out  1  one-cycle pulse on a request with ALUResultM[1:0]!=0.
REQ-012 GpioOut  out  32  memory-mapped output register.

Function
REQ-013 Address map: 0x0000_0000..4*DEPTH_WORDS-1 = RAM; 0x0000_1000 = GpioOut (R/W); 0x0000_1004 = cycle counter (read-only); all else unmapped.
REQ-014 FSM states IDLE, WAIT, DONE; reset state IDLE.
REQ-015 IDLE, aligned load: MemStallM=1 combinationally that cycle; next state WAIT with wait counter=READ_WAIT, or DONE if READ_WAIT=0.
REQ-016 WAIT: MemStallM=1; counter decrements each cycle; at counter=0 transition to DONE.
REQ-017 Load latency: exactly READ_WAIT+1 stall cycles, then DONE.
REQ-018 DONE: MemStallM=0, ReadDataM valid; next state always IDLE, so the same load is never reissued.
REQ-019 A new load in the IDLE cycle after DONE starts a fresh sequence.
REQ-020 Store in IDLE: completes in one cycle, MemStallM=0, RAM/GpioOut updated at that edge, visible to a load starting the next cycle.
REQ-021 ReadDataM updates only on entry to DONE; held at its previous value otherwise.
REQ-022 Misaligned access: no RAM/GPIO write, no stall, MisalignM=1 for that cycle, ReadDataM unchanged.
REQ-023 Unmapped load returns 0x0000_0000 through the normal FSM timing; unmapped store is ignored.
REQ-024 Store to 0x0000_1004 is ignored.
REQ-025 Cycle counter: 32-bit, +1 every non-reset cycle, wraps 0xFFFF_FFFF->0; a load returns the value present on the edge entering DONE.
REQ-026 MemReqM=0: no state change except counter; MemStallM=0, MisalignM=0.

Reset
REQ-027 On reset: state IDLE, ReadDataM=0, GpioOut=0, counter=0, wait counter=0, MisalignM=0.
REQ-028 While reset=0: MemStallM=0 and MisalignM=0 forced.
REQ-029 Reset during WAIT/DONE aborts the load; ReadDataM=0 after the edge.
REQ-030 RAM contents are not reset.

Structure
REQ-031 Shared package dmem_pkg holds the FSM state enum, GPIO_ADDR, CYCLE_ADDR constants.
REQ-032 RAM in sub-module dmem_ram: single-port, synchronous write, word-addressed by ALUResultM[log2(DEPTH_WORDS)+1:2].

Verification
REQ-033 Store 0xDEADBEEF @0x10, then load @0x10 (READ_WAIT=1) -> MemStallM high 2 cycles, ReadDataM=0xDEADBEEF in DONE.
REQ-034 READ_WAIT=0, back-to-back loads @0x0 and @0x4 -> each 1 stall cycle, no reissue of the first load.
REQ-035 Store @0x12 -> MisalignM pulse 1 cycle, RAM @0x10 unchanged, no stall.
REQ-036 Store 0x5A @0x1000, load @0x1000 -> GpioOut=0x5A next cycle, ReadDataM=0x0000_005A; load @0x2000 -> 0.
REQ-037 Counter preloaded by force to 0xFFFF_FFFE, load @0x1004 with READ_WAIT=1 -> ReadDataM=0x0000_0000 (wrapped).
REQ-038 reset=0 during WAIT -> state IDLE, MemStallM=0, ReadDataM=0, GpioOut=0 after edge.
